// File: rtl/mem_ctrl_if.sv
// Bundle of requester, RAM/IO and control signals around the memory controller.
interface mem_ctrl_if #(
  parameter int unsigned LINE_BYTES = 16
);
  logic                    rdy;
  logic                    rollback;
  logic [7:0]              mem_din;
  logic [7:0]              mem_dout;
  logic [31:0]             mem_a;
  logic                    mem_wr;
  logic                    io_buffer_full;
  logic                    if_en;
  logic [31:0]             if_pc;
  logic                    if_done;
  logic [8*LINE_BYTES-1:0] if_data;
  logic                    lsb_en;
  logic                    lsb_wr;
  logic [31:0]             lsb_addr;
  logic [2:0]              lsb_len;
  logic [31:0]             lsb_w_data;
  logic                    lsb_done;
  logic [31:0]             lsb_r_data;

  // Controller side
  modport slave (
    input  rdy, rollback, mem_din, io_buffer_full,
    input  if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
    output mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_r_data
  );

  // Requesters, RAM and global control side
  modport master (
    output rdy, rollback, mem_din, io_buffer_full,
    output if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
    input  mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_r_data
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates LSB and instruction-line refill, serialises
// each access into byte transactions on the RAM/IO bus.
module mem_ctrl #(
  parameter int unsigned LINE_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst,
  mem_ctrl_if.slave  bus
);

  localparam int unsigned KW = $clog2(LINE_BYTES) + 1;
  localparam int unsigned LW = 8 * LINE_BYTES;

  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_t;

  state_t          state;
  logic [KW-1:0]   k;         // byte index currently (or next) on the bus
  logic [KW-1:0]   n;         // access length in bytes
  logic [KW-1:0]   rd_idx;    // index of the read byte arriving on mem_din
  logic [31:0]     base;
  logic [31:0]     w_data;
  logic            is_io;
  logic            sent;      // byte k has been driven onto the bus
  logic            rd_valid;  // mem_din carries byte rd_idx this cycle
  logic [LW-1:0]   line_buf;
  logic [LW-1:0]   line_cap_c;
  logic [KW-1:0]   k_inc_c;
  logic [KW-1:0]   idx_c;
  logic            lsb_elig_c;
  logic            if_elig_c;
  logic            io_req_c;

  assign k_inc_c    = k + KW'(1);
  assign idx_c      = sent ? k_inc_c : k;
  assign lsb_elig_c = bus.lsb_en && !bus.lsb_done;
  assign if_elig_c  = bus.if_en && !bus.if_done;
  assign io_req_c   = (bus.lsb_addr[17:16] == 2'b11);

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  // Line buffer with the byte currently on mem_din merged in
  always_comb begin
    line_cap_c = line_buf;
    for (int i = 0; i < int'(LINE_BYTES); i++) begin
      if (rd_idx == KW'(i)) line_cap_c[8*i +: 8] = bus.mem_din;
    end
  end

  // Controller FSM with registered bus and done outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      k              <= '0;
      n              <= '0;
      rd_idx         <= '0;
      base           <= '0;
      w_data         <= '0;
      is_io          <= 1'b0;
      sent           <= 1'b0;
      rd_valid       <= 1'b0;
      line_buf       <= '0;
      bus.mem_dout   <= '0;
      bus.mem_a      <= '0;
      bus.mem_wr     <= 1'b0;
      bus.if_done    <= 1'b0;
      bus.if_data    <= '0;
      bus.lsb_done   <= 1'b0;
      bus.lsb_r_data <= '0;
    end else begin
      bus.if_done  <= 1'b0;
      bus.lsb_done <= 1'b0;
      if (bus.rollback && (state == IFETCH || state == LOAD)) begin
        state      <= IDLE;
        bus.mem_wr <= 1'b0;
        bus.mem_a  <= '0;
        sent       <= 1'b0;
        rd_valid   <= 1'b0;
      end else if (!bus.rdy) begin
        // Pause: quiet the bus; a read restarts from its oldest uncaptured byte
        bus.mem_wr <= 1'b0;
        bus.mem_a  <= '0;
        if (state == IFETCH || state == LOAD) begin
          sent     <= 1'b0;
          rd_valid <= 1'b0;
          if (rd_valid) k <= rd_idx;
        end
      end else begin
        case (state)
          IDLE: begin
            bus.mem_wr <= 1'b0;
            bus.mem_a  <= '0;
            if (!bus.rollback) begin
              if (lsb_elig_c) begin
                base     <= bus.lsb_addr;
                n        <= KW'(bus.lsb_len);
                k        <= '0;
                w_data   <= bus.lsb_w_data;
                is_io    <= io_req_c;
                rd_valid <= 1'b0;
                line_buf <= '0;
                if (bus.lsb_wr) begin
                  state <= STORE;
                  if (!io_req_c || !bus.io_buffer_full) begin
                    bus.mem_wr   <= 1'b1;
                    bus.mem_a    <= bus.lsb_addr;
                    bus.mem_dout <= bus.lsb_w_data[7:0];
                    sent         <= 1'b1;
                  end else begin
                    sent <= 1'b0;
                  end
                end else begin
                  state     <= LOAD;
                  bus.mem_a <= bus.lsb_addr;
                  sent      <= 1'b1;
                end
              end else if (if_elig_c) begin
                state     <= IFETCH;
                base      <= bus.if_pc;
                n         <= KW'(LINE_BYTES);
                k         <= '0;
                rd_valid  <= 1'b0;
                line_buf  <= '0;
                bus.mem_a <= bus.if_pc;
                sent      <= 1'b1;
              end
            end
          end

          IFETCH, LOAD: begin
            bus.mem_wr <= 1'b0;
            if (rd_valid) line_buf <= line_cap_c;
            if (rd_valid && rd_idx == n - KW'(1)) begin
              state     <= IDLE;
              bus.mem_a <= '0;
              sent      <= 1'b0;
              rd_valid  <= 1'b0;
              if (state == IFETCH) begin
                bus.if_data <= line_cap_c;
                bus.if_done <= 1'b1;
              end else begin
                bus.lsb_r_data <= line_cap_c[31:0];
                bus.lsb_done   <= 1'b1;
              end
            end else begin
              rd_valid <= sent;
              rd_idx   <= k;
              if (sent) begin
                k <= k_inc_c;
                if (k_inc_c < n) begin
                  bus.mem_a <= base + 32'(k_inc_c);
                  sent      <= 1'b1;
                end else begin
                  bus.mem_a <= '0;
                  sent      <= 1'b0;
                end
              end else begin
                bus.mem_a <= base + 32'(k);
                sent      <= 1'b1;
              end
            end
          end

          STORE: begin
            if (sent && k_inc_c == n) begin
              state        <= IDLE;
              k            <= k_inc_c;
              sent         <= 1'b0;
              bus.mem_wr   <= 1'b0;
              bus.mem_a    <= '0;
              bus.lsb_done <= 1'b1;
            end else begin
              k <= idx_c;
              if (!is_io || !bus.io_buffer_full) begin
                bus.mem_wr   <= 1'b1;
                bus.mem_a    <= base + 32'(idx_c);
                bus.mem_dout <= byte_sel(w_data, idx_c[1:0]);
                sent         <= 1'b1;
              end else begin
                bus.mem_wr <= 1'b0;
                bus.mem_a  <= '0;
                sent       <= 1'b0;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed requests push expected bus writes
// and done events; a negedge monitor pops and compares them.
module tb_mem_ctrl;
  localparam int unsigned LB = 16;

  typedef struct { int cyc; logic [31:0] addr; logic [7:0] data; } wr_exp_t;
  typedef struct { int cyc; logic chk; logic [31:0] data; } lsb_exp_t;
  typedef struct { int cyc; logic [8*LB-1:0] data; } if_exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   c;

  logic [7:0] ram [0:1023];
  wr_exp_t  wq[$];
  lsb_exp_t lq[$];
  if_exp_t  iq[$];

  mem_ctrl_if #(.LINE_BYTES(LB)) bus();
  mem_ctrl #(.LINE_BYTES(LB)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.mem_din <= ram[bus.mem_a[9:0]];

  function automatic logic [8*LB-1:0] ram_line(input logic [31:0] a);
    logic [8*LB-1:0] l;
    for (int i = 0; i < int'(LB); i++) l[8*i +: 8] = ram[a[9:0] + 10'(i)];
    return l;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_lsb(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.lsb_done) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL lsb_done_timeout: got no pulse expected one within %0d cycles", budget);
    end
  endtask

  task automatic wait_if(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.if_done) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL if_done_timeout: got no pulse expected one within %0d cycles", budget);
    end
  endtask

  task automatic lsb_req(input logic wr, input logic [31:0] a, input logic [2:0] len,
                         input logic [31:0] d);
    bus.lsb_en     = 1'b1;
    bus.lsb_wr     = wr;
    bus.lsb_addr   = a;
    bus.lsb_len    = len;
    bus.lsb_w_data = d;
  endtask

  // Monitor: pop and compare whenever the DUT writes a byte or pulses done
  initial begin
    wr_exp_t  we;
    lsb_exp_t le;
    if_exp_t  ie;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_wr) begin
          total++;
          if (wq.size() == 0) begin
            bad++;
            $display("FAIL write: got unexpected a=%h d=%h at cycle %0d expected none",
                     bus.mem_a, bus.mem_dout, cyc);
          end else begin
            we = wq.pop_front();
            if (bus.mem_a !== we.addr || bus.mem_dout !== we.data || cyc != we.cyc) begin
              bad++;
              $display("FAIL write: got a=%h d=%h cyc=%0d expected a=%h d=%h cyc=%0d",
                       bus.mem_a, bus.mem_dout, cyc, we.addr, we.data, we.cyc);
            end
          end
        end
        if (bus.lsb_done) begin
          total++;
          if (lq.size() == 0) begin
            bad++;
            $display("FAIL lsb_done: got unexpected pulse at cycle %0d expected none", cyc);
          end else begin
            le = lq.pop_front();
            if ((le.chk && bus.lsb_r_data !== le.data) || (le.cyc >= 0 && cyc != le.cyc)) begin
              bad++;
              $display("FAIL lsb_done: got data=%h cyc=%0d expected data=%h cyc=%0d",
                       bus.lsb_r_data, cyc, le.data, le.cyc);
            end
          end
        end
        if (bus.if_done) begin
          total++;
          if (iq.size() == 0) begin
            bad++;
            $display("FAIL if_done: got unexpected pulse at cycle %0d expected none", cyc);
          end else begin
            ie = iq.pop_front();
            if (bus.if_data !== ie.data || cyc != ie.cyc) begin
              bad++;
              $display("FAIL if_done: got data=%h cyc=%0d expected data=%h cyc=%0d",
                       bus.if_data, cyc, ie.data, ie.cyc);
            end
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i * 7 + 3);
    ram[256] = 8'h11; ram[257] = 8'h22; ram[258] = 8'h33; ram[259] = 8'h44;

    rst = 1'b1;
    bus.rdy = 1'b1; bus.rollback = 1'b0; bus.io_buffer_full = 1'b0;
    bus.if_en = 1'b0; bus.if_pc = '0;
    bus.lsb_en = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_addr = '0; bus.lsb_len = '0; bus.lsb_w_data = '0;
    tick(3);
    check("rst_mem_a", 128'(bus.mem_a), 128'(0));
    check("rst_mem_wr", 128'(bus.mem_wr), 128'(0));
    check("rst_mem_dout", 128'(bus.mem_dout), 128'(0));
    check("rst_dones", 128'({bus.if_done, bus.lsb_done}), 128'(0));
    check("rst_lsb_r_data", 128'(bus.lsb_r_data), 128'(0));
    check("rst_if_data", bus.if_data, 128'(0));
    rst = 1'b0;
    tick(1);

    // LW 0x100
    lsb_req(1'b0, 32'h100, 3'd4, 32'h0); c = cyc;
    lq.push_back('{cyc: c + 6, chk: 1'b1, data: 32'h44332211});
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("lw_addr", 128'(bus.mem_a), 128'(32'h100 + 32'(k)));
    end
    wait_lsb(10);
    tick(1); bus.lsb_en = 1'b0;
    check("lw_no_reaccept", 128'(bus.mem_a), 128'(0));

    // SB to IO with a full output buffer for three cycles
    bus.io_buffer_full = 1'b1;
    lsb_req(1'b1, 32'h30000, 3'd1, 32'hAABBCC41); c = cyc;
    wq.push_back('{cyc: c + 4, addr: 32'h30000, data: 8'h41});
    lq.push_back('{cyc: c + 5, chk: 1'b0, data: 32'h0});
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      check("io_stall_wr", 128'(bus.mem_wr), 128'(0));
      if (i == 3) bus.io_buffer_full = 1'b0;
    end
    wait_lsb(10);
    tick(1); bus.lsb_en = 1'b0;

    // Simultaneous LH 0x200 and line fetch 0x340: LSB first
    lsb_req(1'b0, 32'h200, 3'd2, 32'h0);
    bus.if_en = 1'b1; bus.if_pc = 32'h340; c = cyc;
    lq.push_back('{cyc: c + 4, chk: 1'b1, data: 32'h00000A03});
    iq.push_back('{cyc: c + 22, data: ram_line(32'h340)});
    wait_lsb(10);
    check("if_not_in_done_cycle", 128'(bus.mem_a), 128'(0));
    tick(1); bus.lsb_en = 1'b0;
    check("if_start_addr", 128'(bus.mem_a), 128'(32'h340));
    wait_if(30);
    tick(1); bus.if_en = 1'b0;

    // Line fetch aborted by rollback at k = 5
    bus.if_en = 1'b1; bus.if_pc = 32'h080; c = cyc;
    tick(6);
    check("if_k5_addr", 128'(bus.mem_a), 128'(32'h085));
    bus.rollback = 1'b1; bus.if_en = 1'b0;
    tick(1); bus.rollback = 1'b0;
    check("rb_mem_a", 128'(bus.mem_a), 128'(0));
    check("rb_mem_wr", 128'(bus.mem_wr), 128'(0));
    check("rb_if_done", 128'(bus.if_done), 128'(0));
    tick(20);

    // Request during rollback in IDLE is rejected, then accepted
    bus.rollback = 1'b1; bus.if_en = 1'b1; bus.if_pc = 32'h1C0; c = cyc;
    tick(1);
    check("rb_idle_reject", 128'(bus.mem_a), 128'(0));
    bus.rollback = 1'b0;
    iq.push_back('{cyc: c + 19, data: ram_line(32'h1C0)});
    wait_if(30);
    tick(1); bus.if_en = 1'b0;

    // SW 0xDEADBEEF to 0x80 with rollback mid-store
    lsb_req(1'b1, 32'h80, 3'd4, 32'hDEADBEEF); c = cyc;
    wq.push_back('{cyc: c + 1, addr: 32'h80, data: 8'hEF});
    wq.push_back('{cyc: c + 2, addr: 32'h81, data: 8'hBE});
    wq.push_back('{cyc: c + 3, addr: 32'h82, data: 8'hAD});
    wq.push_back('{cyc: c + 4, addr: 32'h83, data: 8'hDE});
    lq.push_back('{cyc: c + 5, chk: 1'b0, data: 32'h0});
    tick(2); bus.rollback = 1'b1;
    tick(2); bus.rollback = 1'b0;
    wait_lsb(10);
    tick(1); bus.lsb_en = 1'b0;

    // SW with rdy low for two cycles at k = 1
    lsb_req(1'b1, 32'h90, 3'd4, 32'h12345678); c = cyc;
    wq.push_back('{cyc: c + 1, addr: 32'h90, data: 8'h78});
    wq.push_back('{cyc: c + 4, addr: 32'h91, data: 8'h56});
    wq.push_back('{cyc: c + 5, addr: 32'h92, data: 8'h34});
    wq.push_back('{cyc: c + 6, addr: 32'h93, data: 8'h12});
    lq.push_back('{cyc: c + 7, chk: 1'b0, data: 32'h0});
    tick(1); bus.rdy = 1'b0;
    check("rdy_byte0_on_bus", 128'(bus.mem_wr), 128'(1));
    tick(1);
    check("rdy_pause_wr", 128'(bus.mem_wr), 128'(0));
    tick(1); bus.rdy = 1'b1;
    check("rdy_pause_wr2", 128'(bus.mem_wr), 128'(0));
    wait_lsb(10);
    tick(1); bus.lsb_en = 1'b0;

    // LW with a one-cycle pause: data must still assemble correctly
    lsb_req(1'b0, 32'h100, 3'd4, 32'h0);
    lq.push_back('{cyc: -1, chk: 1'b1, data: 32'h44332211});
    tick(2); bus.rdy = 1'b0;
    tick(1); bus.rdy = 1'b1;
    wait_lsb(20);
    tick(1); bus.lsb_en = 1'b0;

    // rst mid-LOAD
    lsb_req(1'b0, 32'h100, 3'd4, 32'h0);
    tick(3); rst = 1'b1;
    tick(1);
    check("mid_rst_mem_a", 128'(bus.mem_a), 128'(0));
    check("mid_rst_mem_wr", 128'(bus.mem_wr), 128'(0));
    check("mid_rst_lsb_done", 128'(bus.lsb_done), 128'(0));
    check("mid_rst_lsb_r_data", 128'(bus.lsb_r_data), 128'(0));
    check("mid_rst_if_data", bus.if_data, 128'(0));
    rst = 1'b0; bus.lsb_en = 1'b0;
    tick(12);

    check("wq_drained", 128'(wq.size()), 128'(0));
    check("lq_drained", 128'(lq.size()), 128'(0));
    check("iq_drained", 128'(iq.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory controller: responder end of the LSB memory-request interface, plus the instruction-fetch line refill port.
- Sits between the ICache/IFetch and LSB above, and the byte-wide unified RAM/IO bus below.
- Arbitrates the two requesters and serialises each multi-byte access into byte transactions.
- Returns assembled little-endian read data with a one-cycle done pulse.

Parameters:
LINE_BYTES, 16, bytes per instruction-fetch line (power of two, >=4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low = pause
rollback  in  1  pipeline flush from ROB
mem_din  in  8  RAM/IO read byte
mem_dout  out  8  RAM/IO write byte
mem_a  out  32  RAM/IO byte address
mem_wr  out  1  1 = write, 0 = read
io_buffer_full  in  1  UART output buffer full
if_en  in  1  line fetch request (held until if_done)
if_pc  in  32  line base address (requester aligns)
if_done  out  1  one-cycle done pulse
if_data  out  8*LINE_BYTES  fetched line, byte 0 in bits [7:0]
lsb_en  in  1  LSB request (held until lsb_done)
lsb_wr  in  1  1 = store
lsb_addr  in  32  byte address
lsb_len  in  3  access length: 1, 2 or 4
lsb_w_data  in  32  store data, low lsb_len bytes used
lsb_done  out  1  one-cycle done pulse
lsb_r_data  out  32  raw load bytes, zero-extended above lsb_len (LSB does sign-extension)

Behaviour:
- Reset: state IDLE; mem_dout, mem_a, mem_wr, if_done, lsb_done, if_data, lsb_r_data all 0; byte counter 0.
- States: IDLE, IFETCH, LOAD, STORE. Byte counter k, length n, base address A.
- IDLE acceptance:
  - A port is ignored while its own done output is high (requester still holds en that cycle).
  - If lsb_en is eligible: go to STORE if lsb_wr, else LOAD; n = lsb_len.
  - Else if if_en is eligible: go to IFETCH; n = LINE_BYTES.
  - LSB has priority on simultaneous requests.
- Timing: the request is sampled in cycle c; the state changes at the end of c.
- Read (LOAD/IFETCH), mem_wr = 0:
  - mem_a = A+k during cycle c+1+k, for k = 0..n-1.
  - Byte k is valid on mem_din in cycle c+2+k and is captured at the end of that cycle.
  - At the edge capturing byte n-1: the data output is registered and done is set. Done is high in cycle c+2+n.
  - The state returns to IDLE at that same edge.
  - Example: LW takes 6 cycles from request to done.
- Write (STORE):
  - mem_wr = 1, mem_a = A+k, mem_dout = lsb_w_data[8k+7:8k] during cycle c+1+k.
  - lsb_done is high in cycle c+1+n, with mem_wr = 0 in that cycle.
- IO stall:
  - An address with A[17:16] = 2'b11 is IO.
  - For an IO store, a byte is issued only at an edge where io_buffer_full is low. Otherwise mem_wr <= 0 and k holds.
- Idle bus: whenever no byte is issued, mem_wr = 0 and mem_a = 0, so no spurious write occurs.
- done pulses last exactly one cycle. if_data and lsb_r_data hold their value until the next completion on the same port.
- rdy low:
  - No state, counter or capture advance; mem_wr <= 0.
  - When rdy returns, the current byte k is re-issued: a read re-presents A+k, a write re-drives byte k.
  - No byte is ever written twice with mem_wr high across the pause.
- rollback (priority below rst, above rdy):
  - IFETCH or LOAD: abort at that edge. State goes to IDLE, mem_wr = 0, no done pulse, partial data discarded.
  - STORE: never aborted (committed store). It runs to completion and still pulses lsb_done.
  - rollback in IDLE: no effect. A request sampled in the rollback cycle is not accepted.
- rst mid-operation: immediate return to reset values; an in-flight write is dropped after the current cycle.
- Address arithmetic: A+k is 32-bit and wraps at 2^32; no alignment check.

Test Plan:
- LW at 0x100, RAM bytes 11 22 33 44 -> mem_a 0x100..0x103 on consecutive cycles; lsb_done high 6 cycles after the request cycle; lsb_r_data = 0x44332211.
- SB 0x30000 with data 0x41, io_buffer_full held high 3 cycles then low -> mem_wr stays 0 during the stall; exactly one write of 0x41 to 0x30000; then lsb_done.
- if_en and lsb_en (LH 0x200) raised in the same cycle -> LH served first. IFETCH starts only after lsb_done, not in the done cycle. if_data equals the 16 RAM bytes at if_pc.
- rollback at k = 5 of IFETCH -> mem_wr = 0, no if_done, IDLE next cycle. A new if_en to another pc then completes with the correct line.
- rollback during SW 0xDEADBEEF to 0x80 -> all four bytes EF BE AD DE written to 0x80..0x83; lsb_done pulses once.
- rdy low for 2 cycles at k = 1 of SW -> byte 1 written exactly once after rdy rises; rst asserted mid-LOAD -> all outputs 0 next cycle, no done.
